// File: rtl/alu_modport_pkg.sv
// Shared opcode encoding and width constants
// for the registered 32-bit signed ALU.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

endpackage

// File: rtl/alu_modport_if.sv
// Operand/result bundle between the stimulus
// side (master) and the ALU (slave).
interface alu_modport_if;
  import alu_pkg::*;

  logic signed [DATA_W-1:0] A;
  logic signed [DATA_W-1:0] B;
  logic [2:0]               opcode;
  logic [DATA_W-1:0]        Result;
  logic                     Error;

  modport master (
    output A, B, opcode,
    input  Result, Error
  );

  modport slave (
    input  A, B, opcode,
    output Result, Error
  );
endinterface

// File: rtl/alu_modport_core.sv
// Combinational next-state logic for the ALU:
// result and error for every opcode.
module alu_core
  import alu_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic [2:0]               i_op,
  output logic [DATA_W-1:0]        o_result,
  output logic                     o_error
);

  op_e                       w_op;
  logic [DATA_W:0]           w_add;
  logic [DATA_W:0]           w_sub;
  logic signed [2*DATA_W-1:0] w_prod;
  logic                      w_div_zero;
  logic                      w_div_ovf;
  logic signed [DATA_W-1:0]  w_div_b;
  logic signed [DATA_W-1:0]  w_quo;

  assign w_op  = op_e'(i_op);
  assign w_add = {i_a[DATA_W-1], i_a} + {i_b[DATA_W-1], i_b};
  assign w_sub = {i_a[DATA_W-1], i_a} - {i_b[DATA_W-1], i_b};
  assign w_prod =
    $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) *
    $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});

  assign w_div_zero = (i_b == '0);
  assign w_div_ovf  = (i_a == INT_MIN) && (i_b == '1);
  // Keep the divider away from its undefined cases.
  assign w_div_b = (w_div_zero || w_div_ovf) ? 32'sd1 : i_b;
  assign w_quo   = i_a / w_div_b;

  always_comb begin
    o_result = '0;
    o_error  = 1'b0;
    unique case (w_op)
      OP_ADD: begin
        o_result = w_add[DATA_W-1:0];
        o_error  = w_add[DATA_W] ^ w_add[DATA_W-1];
      end
      OP_SUB: begin
        o_result = w_sub[DATA_W-1:0];
        o_error  = w_sub[DATA_W] ^ w_sub[DATA_W-1];
      end
      OP_MUL: begin
        o_result = w_prod[DATA_W-1:0];
        o_error  = !((&w_prod[2*DATA_W-1:DATA_W-1]) ||
                     ~|w_prod[2*DATA_W-1:DATA_W-1]);
      end
      OP_DIV: begin
        if (w_div_zero) begin
          o_result = '0;
          o_error  = 1'b1;
        end else if (w_div_ovf) begin
          o_result = INT_MIN;
          o_error  = 1'b1;
        end else begin
          o_result = w_quo;
        end
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_RSVD: begin
        o_result = '0;
        o_error  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_modport.sv
// Registered 32-bit signed ALU: one operation
// per cycle, one-cycle latency.
module alu_modport
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_modport_if.slave bus
);

  logic [DATA_W-1:0] w_result;
  logic              w_error;
  logic [DATA_W-1:0] r_result;
  logic              r_error;

  alu_core u_core (
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_op     (bus.opcode),
    .o_result (w_result),
    .o_error  (w_error)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      r_result <= w_result;
      r_error  <= w_error;
    end
  end

  assign bus.Result = r_result;
  assign bus.Error  = r_error;

endmodule

// File: tb/tb_alu_modport.sv
// Directed and randomized checks of alu_modport
// against an integer-arithmetic reference model.
module tb_alu_modport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  alu_modport_if bus ();

  alu_modport dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  function automatic logic [32:0] model(
    input logic [2:0] op, input int a, input int b);
    longint r;
    logic   e;
    logic [63:0] rv;
    r = 0;
    e = 1'b0;
    case (op)
      3'd0: begin
        r = longint'(a) + longint'(b);
        e = (r > MAXI) || (r < MINI);
      end
      3'd1: begin
        r = longint'(a) - longint'(b);
        e = (r > MAXI) || (r < MINI);
      end
      3'd2: begin
        r = longint'(a) * longint'(b);
        e = (r > MAXI) || (r < MINI);
      end
      3'd3: begin
        if (b == 0) begin
          r = 0; e = 1'b1;
        end else if (a == int'(MINI) && b == -1) begin
          r = MINI; e = 1'b1;
        end else begin
          r = longint'(a / b);
        end
      end
      3'd4: r = longint'(a & b);
      3'd5: r = longint'(a | b);
      3'd6: r = longint'(a ^ b);
      default: begin
        r = 0; e = 1'b1;
      end
    endcase
    rv = r;
    return {e, rv[31:0]};
  endfunction

  task automatic step(input logic rs, input logic [2:0] op,
                      input int a, input int b,
                      input logic [31:0] er, input logic ee,
                      input string tag);
    @(negedge clk);
    rst = rs;
    bus.opcode = op;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    total++;
    assert (bus.Result === er && bus.Error === ee) else begin
      bad++;
      $display("FAIL %s: got res=%h err=%b want res=%h err=%b",
               tag, bus.Result, bus.Error, er, ee);
      $error("check %s differs", tag);
    end
  endtask

  task automatic mstep(input logic [2:0] op, input int a,
                       input int b, input string tag);
    logic [32:0] m;
    m = model(op, a, b);
    step(1'b0, op, a, b, m[31:0], m[32], tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bus.A = 0;
    bus.B = 0;
    bus.opcode = 3'd0;

    step(1'b1, 3'd0, 5, 3, 32'd0, 1'b0, "reset0");
    step(1'b1, 3'd0, 5, 3, 32'd0, 1'b0, "reset1");
    step(1'b0, 3'd0, 5, 3, 32'd8, 1'b0, "first_op");

    step(1'b0, 3'd0, -7, 3, 32'hFFFF_FFFC, 1'b0, "add");
    step(1'b0, 3'd1, 3, 10, 32'hFFFF_FFF9, 1'b0, "sub");
    step(1'b0, 3'd2, -6, 7, 32'hFFFF_FFD6, 1'b0, "mul");
    step(1'b0, 3'd3, -7, 2, 32'hFFFF_FFFD, 1'b0, "div");

    step(1'b0, 3'd0, 32'h7FFF_FFFF, 1,
         32'h8000_0000, 1'b1, "add_ovf");
    step(1'b0, 3'd1, 32'h8000_0000, 1,
         32'h7FFF_FFFF, 1'b1, "sub_ovf");
    step(1'b0, 3'd2, 32'h1_0000, 32'h1_0000,
         32'h0, 1'b1, "mul_ovf");
    step(1'b0, 3'd3, 100, 0, 32'h0, 1'b1, "div_zero");
    step(1'b0, 3'd3, 32'h8000_0000, -1,
         32'h8000_0000, 1'b1, "div_ovf");

    step(1'b0, 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00,
         32'hF000_F000, 1'b0, "and");
    step(1'b0, 3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00,
         32'hFFF0_FFF0, 1'b0, "or");
    step(1'b0, 3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00,
         32'h0FF0_0FF0, 1'b0, "xor");
    step(1'b0, 3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00,
         32'h0, 1'b1, "rsvd");

    step(1'b0, 3'd0, 32'h8000_0000, 32'h8000_0000,
         32'h0, 1'b1, "add_neg_ovf");
    step(1'b0, 3'd1, 0, 32'h8000_0000,
         32'h8000_0000, 1'b1, "sub_neg_b");
    step(1'b0, 3'd2, 32'h8000, -32'sh1_0000,
         32'h8000_0000, 1'b0, "mul_min");

    for (int i = 0; i < 64; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) begin
        ra = $urandom_range(0, 2000) - 1000;
        rb = $urandom_range(0, 60) - 30;
      end
      if (i == 29) begin
        step(1'b1, 3'(i % 8), int'(ra), int'(rb),
             32'h0, 1'b0, "rand_reset");
      end else begin
        mstep(3'(i % 8), int'(ra), int'(rb), "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
